hit_judge: RTL



---
 rtl/hit_judge.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/hit_judge.sv
// hit_judge: whack-a-hole judge; debounced keys scored against the 1 s mole.
// Define HIT_JUDGE_MISS_LIMIT_EN to also end the game once miss reaches MAX_MISS.
module hit_judge #(
  parameter int DEB_CYCLES = 20000,
  parameter int ROUNDS     = 30,
  parameter int MAX_MISS   = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       clk1s,
  input  logic [1:0] seq,
  input  logic       start,
  input  logic [3:0] key_n,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [7:0] miss,
  output logic       game_over,
  output logic       hit_p
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [6:0] RND_MAX = 7'(ROUNDS);
  localparam logic [6:0] MISS_LIM = 7'(MAX_MISS);
`ifdef HIT_JUDGE_MISS_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ACTIVE,
    S_RESOLVED,
    S_DONE
  } state_t;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_val(
    input logic [7:0] v
  );
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  logic          r_c1s_s1;
  logic          r_c1s_s2;
  logic          r_c1s_d;
  logic          r_tick;
  logic [1:0]    r_seq_s1;
  logic [1:0]    r_seq_s2;
  logic [3:0]    r_key_s1;
  logic [3:0]    r_key_s2;
  logic [3:0]    r_deb;
  logic [3:0]    r_press;
  logic [CW-1:0] r_cnt [4];

  state_t     r_state;
  state_t     w_state_nx;
  logic [3:0] r_mole;
  logic [3:0] w_mole_nx;
  logic [7:0] r_score;
  logic [7:0] w_score_nx;
  logic [7:0] r_miss;
  logic [7:0] w_miss_nx;
  logic [6:0] r_round;
  logic [6:0] w_round_nx;
  logic       r_hit_p;
  logic       w_hit_nx;
  logic       r_seen_low;
  logic       w_seen_low_nx;

  logic [3:0] w_dec;
  logic [7:0] w_miss_tk;
  logic       w_lim;
  logic       w_end;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_c1s_s1 <= 1'b0;
      r_c1s_s2 <= 1'b0;
      r_c1s_d  <= 1'b0;
      r_tick   <= 1'b0;
      r_seq_s1 <= 2'd0;
      r_seq_s2 <= 2'd0;
      r_key_s1 <= 4'hF;
      r_key_s2 <= 4'hF;
    end else begin
      r_c1s_s1 <= clk1s;
      r_c1s_s2 <= r_c1s_s1;
      r_c1s_d  <= r_c1s_s2;
      r_tick   <= r_c1s_s2 & ~r_c1s_d;
      r_seq_s1 <= seq;
      r_seq_s2 <= r_seq_s1;
      r_key_s1 <= key_n;
      r_key_s2 <= r_key_s1;
    end
  end

  // A key flips only after DEB_CYCLES samples that all disagree with it.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_deb   <= 4'hF;
      r_press <= 4'h0;
      for (int i = 0; i < 4; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_key_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_MAX) begin
          r_cnt[i]   <= '0;
          r_deb[i]   <= r_key_s2[i];
          r_press[i] <= r_deb[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_dec = 4'b0001 << r_seq_s2;
  assign w_miss_tk = (r_state == S_ACTIVE)
                     ? bcd_inc(r_miss) : r_miss;
  assign w_lim = (bcd_val(w_miss_tk) >= MISS_LIM);
  assign w_end = (r_round == RND_MAX)
                 | (LIM_EN & w_lim);

  always_comb begin
    w_state_nx    = r_state;
    w_mole_nx     = r_mole;
    w_score_nx    = r_score;
    w_miss_nx     = r_miss;
    w_round_nx    = r_round;
    w_hit_nx      = 1'b0;
    w_seen_low_nx = r_seen_low;
    unique case (r_state)
      S_IDLE: begin
        w_mole_nx = 4'h0;
        if (start) begin
          w_state_nx = S_ARMED;
          w_score_nx = 8'h00;
          w_miss_nx  = 8'h00;
          w_round_nx = 7'd0;
        end
      end
      S_ARMED: begin
        if (r_tick) begin
          w_mole_nx  = w_dec;
          w_round_nx = r_round + 7'd1;
          w_state_nx = S_ACTIVE;
        end
      end
      S_ACTIVE, S_RESOLVED: begin
        // The tick wins: presses on a round-start cycle are dropped.
        if (r_tick) begin
          w_miss_nx = w_miss_tk;
          if (w_end) begin
            w_mole_nx     = 4'h0;
            w_state_nx    = S_DONE;
            w_seen_low_nx = 1'b0;
          end else begin
            w_mole_nx  = w_dec;
            w_round_nx = r_round + 7'd1;
            w_state_nx = S_ACTIVE;
          end
        end else if (r_state == S_ACTIVE && |r_press) begin
          w_mole_nx  = 4'h0;
          w_state_nx = S_RESOLVED;
          if (r_press == r_mole) begin
            w_score_nx = bcd_inc(r_score);
            w_hit_nx   = 1'b1;
          end else begin
            w_miss_nx = bcd_inc(r_miss);
          end
        end
      end
      S_DONE: begin
        w_mole_nx = 4'h0;
        if (!start) begin
          w_seen_low_nx = 1'b1;
        end else if (r_seen_low) begin
          w_state_nx    = S_ARMED;
          w_score_nx    = 8'h00;
          w_miss_nx     = 8'h00;
          w_round_nx    = 7'd0;
          w_seen_low_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_mole_nx  = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_mole     <= 4'h0;
      r_score    <= 8'h00;
      r_miss     <= 8'h00;
      r_round    <= 7'd0;
      r_hit_p    <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_mole     <= w_mole_nx;
      r_score    <= w_score_nx;
      r_miss     <= w_miss_nx;
      r_round    <= w_round_nx;
      r_hit_p    <= w_hit_nx;
      r_seen_low <= w_seen_low_nx;
    end
  end

  assign mole      = r_mole;
  assign score     = r_score;
  assign miss      = r_miss;
  assign hit_p     = r_hit_p;
  assign game_over = (r_state == S_DONE);

endmodule
